sr_bank_ctrl: RTL

- Sequencer and round-robin arbiter that shares one bank of NBITS edge-triggered SR flip-flops between NREQ requesters.
- Each requester asks to set or reset one bit. The block grants one request at a time and drives a single-cycle S or R pulse to the target flop.
- It reads the flop's Q back and reports success or failure.
- S and R are never driven high together on any bit, so the bank can never enter its undefined S=R=1 state.

---
 rtl/sr_bank_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/sr_bank_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sr_bank_pkg.sv
// rtl/sr_bank_pkg.sv - shared types and helpers for the SR flop bank sequencer
package sr_bank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

    // Bits needed to address NBITS flops; never less than one.
    function automatic int idx_width(input int nbits);
        return (nbits > 1) ? $clog2(nbits) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IW-1:0]   gnt_id,
    output logic            gnt_any
);

    // Two passes: requesters at or above ptr first, then the wrapped ones.
    always_comb begin
        gnt_oh  = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req[k] && (k >= int'(ptr))) begin
                gnt_any   = 1'b1;
                gnt_oh[k] = 1'b1;
                gnt_id    = IW'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req[k] && (k < int'(ptr))) begin
                gnt_any   = 1'b1;
                gnt_oh[k] = 1'b1;
                gnt_id    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/sr_bank_ctrl.sv
// rtl/sr_bank_ctrl.sv - arbitrated set/reset sequencer for a bank of SR flops
module sr_bank_ctrl
    import sr_bank_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_op,
    input  logic [NREQ*IDXW-1:0]     req_idx,
    output logic [NREQ-1:0]          gnt,
    output logic [NBITS-1:0]         s_out,
    output logic [NBITS-1:0]         r_out,
    input  logic [NBITS-1:0]         q_in,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic                     err
);

    localparam int PW = $clog2(NREQ);
    localparam int BW = idx_width(NBITS);

    state_t            state, state_n;
    logic [PW-1:0]     ptr, ptr_n, cur_id, id_n;
    logic              cur_op, op_n;
    logic [BW-1:0]     cur_idx, idx_n;
    logic [NREQ-1:0]   gnt_n;
    logic [NBITS-1:0]  s_n, r_n;
    logic              busy_n, done_n, err_n;
    logic [PW-1:0]     done_id_n;

    logic [NREQ-1:0]   win_oh;
    logic [PW-1:0]     win_id;
    logic              win_any;
    logic              win_op;
    logic [IDXW-1:0]   win_idx;

    rr_arbiter #(.NREQ(NREQ), .IW(PW)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt_oh  (win_oh),
        .gnt_id  (win_id),
        .gnt_any (win_any)
    );

    always_comb begin
        win_op  = OP_RST;
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_oh[k]) begin
                win_op  = req_op[k];
                win_idx = req_idx[k*IDXW +: IDXW];
            end
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        op_n      = cur_op;
        idx_n     = cur_idx;
        id_n      = cur_id;
        gnt_n     = '0;
        s_n       = '0;
        r_n       = '0;
        done_n    = 1'b0;
        done_id_n = done_id;
        err_n     = err;
        case (state)
            IDLE: begin
                if (win_any) begin
                    gnt_n = win_oh;
                    op_n  = win_op;
                    idx_n = win_idx[BW-1:0];
                    id_n  = win_id;
                    if (int'(win_idx) < NBITS) begin
                        // Pulse is registered here so it coincides with DRIVE.
                        state_n = DRIVE;
                        err_n   = 1'b0;
                        if (win_op == OP_SET) s_n[win_idx[BW-1:0]] = 1'b1;
                        else                  r_n[win_idx[BW-1:0]] = 1'b1;
                    end else begin
                        state_n = REPORT;
                        err_n   = 1'b1;
                    end
                end
            end
            DRIVE: state_n = SETTLE;
            SETTLE: begin
                err_n     = (q_in[cur_idx] != cur_op);
                done_n    = 1'b1;
                done_id_n = cur_id;
                state_n   = REPORT;
            end
            REPORT: begin
                // Out-of-range entries arrive with done low and spend one extra cycle here.
                if (done) begin
                    state_n = IDLE;
                    ptr_n   = (cur_id == PW'(NREQ - 1)) ? '0 : cur_id + PW'(1);
                end else begin
                    done_n    = 1'b1;
                    done_id_n = cur_id;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cur_op  <= OP_RST;
            cur_idx <= '0;
            cur_id  <= '0;
            gnt     <= '0;
            s_out   <= '0;
            r_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cur_op  <= op_n;
            cur_idx <= idx_n;
            cur_id  <= id_n;
            gnt     <= gnt_n;
            s_out   <= s_n;
            r_out   <= r_n;
            busy    <= busy_n;
            done    <= done_n;
            done_id <= done_id_n;
            err     <= err_n;
        end
    end

endmodule
